// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter_if
//  Description : Bundles the writeback, MDU-result, register-file write-port
//                and hazard-query signals of the write-port arbiter.
//                master = the surrounding pipeline/MDU/RF side,
//                slave  = the arbiter itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RF_WIDTH   = 5,
    parameter int DEPTH      = 4
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    // writeback stage (MEM/WB register outputs)
    logic                  regWriteW;
    logic [RF_WIDTH-1:0]   regAddr3W;
    logic [DATA_WIDTH-1:0] regDin3W;

    // MDU result handshake
    logic                  mduValid;
    logic                  mduReady;
    logic [RF_WIDTH-1:0]   mduAddr;
    logic [DATA_WIDTH-1:0] mduData;

    // register-file write port
    logic                  rfWe;
    logic [RF_WIDTH-1:0]   rfAddr;
    logic [DATA_WIDTH-1:0] rfDin;

    // hazard-unit query and status
    logic [RF_WIDTH-1:0]   queryAddr;
    logic                  queryPending;
    logic [c_CNT_W-1:0]    fifoCount;

    modport master (
        output regWriteW, regAddr3W, regDin3W,
        output mduValid, mduAddr, mduData,
        output queryAddr,
        input  mduReady,
        input  rfWe, rfAddr, rfDin,
        input  queryPending, fifoCount
    );

    modport slave (
        input  regWriteW, regAddr3W, regDin3W,
        input  mduValid, mduAddr, mduData,
        input  queryAddr,
        output mduReady,
        output rfWe, rfAddr, rfDin,
        output queryPending, fifoCount
    );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_port_arbiter
//  Description : Shares the single register-file write port between the
//                in-order writeback stage (always wins) and an out-of-order
//                multiply/divide unit whose results are buffered in a small
//                FIFO and drained into idle writeback slots. Provides a
//                pending-destination query for the hazard unit.
//                Optional macro WB_PORT_BYPASS_EN: an MDU result arriving
//                while the FIFO is empty and the port is idle drives the
//                port directly in the same cycle instead of being queued.
//                DEPTH must be a power of two and at least 2.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int RF_WIDTH   = 5,
    parameter int DEPTH      = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    wb_port_arbiter_if.slave bus
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [c_CNT_W-1:0]  c_CNT_FULL  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_ZERO  = '0;
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [RF_WIDTH-1:0] c_REG_ZERO  = '0;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [RF_WIDTH-1:0]   r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [c_CNT_W-1:0]    r_count;

    // ------------------------------------------------------------------
    // Control wires
    // ------------------------------------------------------------------
    logic                  w_busy;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_nonempty;
    logic [DEPTH-1:0]      w_match;
    logic                  w_rf_we;
    logic [RF_WIDTH-1:0]   w_rf_addr;
    logic [DATA_WIDTH-1:0] w_rf_din;

    // A writeback to x0 is a no-op, so it does not occupy the port.
    assign w_busy     = bus.regWriteW && (bus.regAddr3W != c_REG_ZERO);
    assign w_nonempty = (r_count != c_CNT_ZERO);

    // Ready comes only from registered occupancy: a full FIFO refuses a new
    // result even when its head drains in the same cycle.
    assign w_ready    = !rst && (r_count < c_CNT_FULL);
    assign w_accept   = bus.mduValid && w_ready;

`ifdef WB_PORT_BYPASS_EN
    // Empty FIFO and idle port: the MDU result goes straight to the port.
    assign w_bypass   = !rst && !w_nonempty && !w_busy && bus.mduValid
                        && (bus.mduAddr != c_REG_ZERO);
`else
    assign w_bypass   = 1'b0;
`endif

    // Results targeting x0 complete the handshake but are dropped.
    assign w_push     = w_accept && (bus.mduAddr != c_REG_ZERO) && !w_bypass;
    assign w_pop      = !rst && !w_busy && w_nonempty;

    // Write-port selection: writeback first, then FIFO head, then bypass.
    always_comb begin
        w_rf_we   = 1'b0;
        w_rf_addr = bus.regAddr3W;
        w_rf_din  = bus.regDin3W;
        if (rst) begin
            w_rf_we = 1'b0;
        end else if (w_busy) begin
            w_rf_we = 1'b1;
        end else if (w_nonempty) begin
            w_rf_we   = 1'b1;
            w_rf_addr = r_addr[r_rptr];
            w_rf_din  = r_data[r_rptr];
        end else if (w_bypass) begin
            w_rf_we   = 1'b1;
            w_rf_addr = bus.mduAddr;
            w_rf_din  = bus.mduData;
        end
    end

    // Pointers, occupancy and entry-valid bits; reset flushes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_pop) begin
                r_rptr          <= r_rptr + c_PTR_ONE;
                r_valid[r_rptr] <= 1'b0;
            end
            if (w_push) begin
                r_wptr          <= r_wptr + c_PTR_ONE;
                r_valid[r_wptr] <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload; validity is tracked separately so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= bus.mduAddr;
            r_data[r_wptr] <= bus.mduData;
        end
    end

    // Per-entry destination match for the hazard query (head included).
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_match[gi] = r_valid[gi] && (r_addr[gi] == bus.queryAddr);
        end
    endgenerate

    assign bus.queryPending = (|w_match) && (bus.queryAddr != c_REG_ZERO);
    assign bus.mduReady     = w_ready;
    assign bus.fifoCount    = r_count;
    assign bus.rfWe         = w_rf_we;
    assign bus.rfAddr       = w_rf_addr;
    assign bus.rfDin        = w_rf_din;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_port_arbiter
//  Description : Directed self-checking bench for wb_port_arbiter.
//                Inputs change 1 ns after the rising edge, outputs are
//                compared 3 ns after the rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DATA_WIDTH = 32;
    localparam int RF_WIDTH   = 5;
    localparam int DEPTH      = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    wb_port_arbiter_if #(.DATA_WIDTH(DATA_WIDTH), .RF_WIDTH(RF_WIDTH), .DEPTH(DEPTH)) bus ();

    wb_port_arbiter #(.DATA_WIDTH(DATA_WIDTH), .RF_WIDTH(RF_WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.regWriteW = we;
        bus.regAddr3W = a;
        bus.regDin3W  = d;
    endtask

    task automatic drive_mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.mduValid = v;
        bus.mduAddr  = a;
        bus.mduData  = d;
    endtask

    task automatic test_reset();
        drive_wb(1'b1, 5'd7, 32'h1234_5678);
        settle();
        total++;
        if ({bus.rfWe, bus.mduReady, bus.queryPending, bus.fifoCount} !== 6'b000_000) begin
            bad++;
            $display("FAIL reset_outputs: got we/rdy/pend/cnt=%b want 000000",
                     {bus.rfWe, bus.mduReady, bus.queryPending, bus.fifoCount});
        end
        step();
        rst = 1'b0;
        drive_wb(1'b0, 5'd0, 32'h0);
        settle();
        total++;
        if ({bus.mduReady, bus.fifoCount, bus.rfWe} !== 5'b1_000_0) begin
            bad++;
            $display("FAIL reset_release: got rdy/cnt/we=%b want 10000",
                     {bus.mduReady, bus.fifoCount, bus.rfWe});
        end
    endtask

    task automatic test_pipeline();
        drive_wb(1'b1, 5'd7, 32'hDEAD_BEEF);
        settle();
        total++;
        if ({bus.rfWe, bus.rfAddr, bus.rfDin} !== {1'b1, 5'd7, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL pipe_x7: got we=%b addr=%0d din=%h want we=1 addr=7 din=deadbeef",
                     bus.rfWe, bus.rfAddr, bus.rfDin);
        end
        step();
        drive_wb(1'b1, 5'd31, 32'hCAFE_0001);
        settle();
        total++;
        if ({bus.rfWe, bus.rfAddr, bus.rfDin} !== {1'b1, 5'd31, 32'hCAFE_0001}) begin
            bad++;
            $display("FAIL pipe_x31: got we=%b addr=%0d din=%h want we=1 addr=31 din=cafe0001",
                     bus.rfWe, bus.rfAddr, bus.rfDin);
        end
        step();
        drive_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        settle();
        total++;
        if (bus.rfWe !== 1'b0) begin
            bad++;
            $display("FAIL pipe_x0: got we=%b want 0", bus.rfWe);
        end
        step();
        drive_wb(1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_contention();
        drive_wb(1'b1, 5'd3, 32'h33);
        drive_mdu(1'b1, 5'd5, 32'h11);
        bus.queryAddr = 5'd5;
        settle();
        total++;
        if ({bus.rfAddr, bus.mduReady, bus.queryPending} !== {5'd3, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL cont_c0: got addr=%0d rdy=%b pend=%b want addr=3 rdy=1 pend=0",
                     bus.rfAddr, bus.mduReady, bus.queryPending);
        end
        step();
        drive_mdu(1'b0, 5'd0, 32'h0);
        for (int c = 1; c < 3; c++) begin
            settle();
            total++;
            if ({bus.rfWe, bus.rfAddr, bus.queryPending, bus.fifoCount} !== {1'b1, 5'd3, 1'b1, 3'd1}) begin
                bad++;
                $display("FAIL cont_c%0d: got we=%b addr=%0d pend=%b cnt=%0d want we=1 addr=3 pend=1 cnt=1",
                         c, bus.rfWe, bus.rfAddr, bus.queryPending, bus.fifoCount);
            end
            step();
        end
        drive_wb(1'b0, 5'd0, 32'h0);
        settle();
        total++;
        if ({bus.rfWe, bus.rfAddr, bus.rfDin, bus.queryPending} !== {1'b1, 5'd5, 32'h11, 1'b1}) begin
            bad++;
            $display("FAIL cont_drain: got we=%b addr=%0d din=%h pend=%b want we=1 addr=5 din=11 pend=1",
                     bus.rfWe, bus.rfAddr, bus.rfDin, bus.queryPending);
        end
        step();
        settle();
        total++;
        if ({bus.rfWe, bus.queryPending, bus.fifoCount} !== {1'b0, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL cont_after: got we=%b pend=%b cnt=%0d want we=0 pend=0 cnt=0",
                     bus.rfWe, bus.queryPending, bus.fifoCount);
        end
        bus.queryAddr = 5'd0;
    endtask

    task automatic test_full();
        logic [4:0]  exp_a [5];
        logic [31:0] exp_d [5];
        exp_a = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
        exp_d = '{32'h101, 32'h102, 32'h103, 32'h104, 32'h600};
        drive_wb(1'b1, 5'd10, 32'hAAAA);
        for (int i = 1; i <= 4; i++) begin
            drive_mdu(1'b1, 5'(i), 32'h100 + 32'(i));
            settle();
            total++;
            if (bus.mduReady !== 1'b1) begin
                bad++;
                $display("FAIL full_push%0d_ready: got %b want 1", i, bus.mduReady);
            end
            step();
        end
        drive_mdu(1'b1, 5'd6, 32'h600);
        for (int h = 0; h < 2; h++) begin
            settle();
            total++;
            if ({bus.mduReady, bus.fifoCount, bus.rfAddr} !== {1'b0, 3'd4, 5'd10}) begin
                bad++;
                $display("FAIL full_hold%0d: got rdy=%b cnt=%0d addr=%0d want rdy=0 cnt=4 addr=10",
                         h, bus.mduReady, bus.fifoCount, bus.rfAddr);
            end
            step();
        end
        drive_wb(1'b0, 5'd0, 32'h0);
        settle();
        total++;
        if (bus.mduReady !== 1'b0) begin
            bad++;
            $display("FAIL full_no_passthru: got rdy=%b want 0", bus.mduReady);
        end
        for (int k = 0; k < 5; k++) begin
            settle();
            total++;
            if ({bus.rfWe, bus.rfAddr, bus.rfDin} !== {1'b1, exp_a[k], exp_d[k]}) begin
                bad++;
                $display("FAIL full_order%0d: got we=%b addr=%0d din=%h want we=1 addr=%0d din=%h",
                         k, bus.rfWe, bus.rfAddr, bus.rfDin, exp_a[k], exp_d[k]);
            end
            if (k == 1) begin
                total++;
                if ({bus.mduReady, bus.fifoCount} !== {1'b1, 3'd3}) begin
                    bad++;
                    $display("FAIL full_reopen: got rdy=%b cnt=%0d want rdy=1 cnt=3",
                             bus.mduReady, bus.fifoCount);
                end
            end
            step();
            if (k == 1) drive_mdu(1'b0, 5'd0, 32'h0);
            #0;
        end
        settle();
        total++;
        if ({bus.rfWe, bus.fifoCount} !== {1'b0, 3'd0}) begin
            bad++;
            $display("FAIL full_empty: got we=%b cnt=%0d want we=0 cnt=0", bus.rfWe, bus.fifoCount);
        end
    endtask

    task automatic test_simultaneous();
        drive_wb(1'b1, 5'd20, 32'h2020);
        drive_mdu(1'b1, 5'd10, 32'hA0);
        step();
        drive_mdu(1'b1, 5'd11, 32'hB0);
        step();
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_mdu(1'b1, 5'd12, 32'hC0);
        settle();
        total++;
        if ({bus.fifoCount, bus.rfWe, bus.rfAddr, bus.rfDin} !== {3'd2, 1'b1, 5'd10, 32'hA0}) begin
            bad++;
            $display("FAIL sim_pushpop: got cnt=%0d we=%b addr=%0d din=%h want cnt=2 we=1 addr=10 din=a0",
                     bus.fifoCount, bus.rfWe, bus.rfAddr, bus.rfDin);
        end
        step();
        drive_wb(1'b1, 5'd20, 32'h2020);
        drive_mdu(1'b1, 5'd0, 32'hFF);
        bus.queryAddr = 5'd12;
        settle();
        total++;
        if ({bus.fifoCount, bus.mduReady, bus.queryPending} !== {3'd2, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL sim_count_kept: got cnt=%0d rdy=%b pend12=%b want cnt=2 rdy=1 pend12=1",
                     bus.fifoCount, bus.mduReady, bus.queryPending);
        end
        step();
        drive_mdu(1'b0, 5'd0, 32'h0);
        drive_wb(1'b0, 5'd0, 32'h0);
        bus.queryAddr = 5'd10;
        settle();
        total++;
        if ({bus.fifoCount, bus.queryPending, bus.rfAddr, bus.rfDin} !== {3'd2, 1'b0, 5'd11, 32'hB0}) begin
            bad++;
            $display("FAIL sim_x0_drop: got cnt=%0d pend10=%b addr=%0d din=%h want cnt=2 pend10=0 addr=11 din=b0",
                     bus.fifoCount, bus.queryPending, bus.rfAddr, bus.rfDin);
        end
        step();
        settle();
        total++;
        if ({bus.rfWe, bus.rfAddr, bus.rfDin} !== {1'b1, 5'd12, 32'hC0}) begin
            bad++;
            $display("FAIL sim_last: got we=%b addr=%0d din=%h want we=1 addr=12 din=c0",
                     bus.rfWe, bus.rfAddr, bus.rfDin);
        end
        step();
        bus.queryAddr = 5'd0;
        settle();
        total++;
        if ({bus.rfWe, bus.fifoCount} !== {1'b0, 3'd0}) begin
            bad++;
            $display("FAIL sim_empty: got we=%b cnt=%0d want we=0 cnt=0", bus.rfWe, bus.fifoCount);
        end
    endtask

    task automatic test_latency();
        drive_mdu(1'b1, 5'd9, 32'h42);
        settle();
`ifdef WB_PORT_BYPASS_EN
        total++;
        if ({bus.rfWe, bus.rfAddr, bus.rfDin, bus.mduReady} !== {1'b1, 5'd9, 32'h42, 1'b1}) begin
            bad++;
            $display("FAIL byp_same_cycle: got we=%b addr=%0d din=%h rdy=%b want we=1 addr=9 din=42 rdy=1",
                     bus.rfWe, bus.rfAddr, bus.rfDin, bus.mduReady);
        end
        step();
        drive_mdu(1'b0, 5'd0, 32'h0);
        settle();
        total++;
        if ({bus.rfWe, bus.fifoCount} !== {1'b0, 3'd0}) begin
            bad++;
            $display("FAIL byp_not_queued: got we=%b cnt=%0d want we=0 cnt=0", bus.rfWe, bus.fifoCount);
        end
`else
        total++;
        if ({bus.rfWe, bus.mduReady} !== {1'b0, 1'b1}) begin
            bad++;
            $display("FAIL lat_cycle0: got we=%b rdy=%b want we=0 rdy=1", bus.rfWe, bus.mduReady);
        end
        step();
        drive_mdu(1'b0, 5'd0, 32'h0);
        settle();
        total++;
        if ({bus.rfWe, bus.rfAddr, bus.rfDin, bus.fifoCount} !== {1'b1, 5'd9, 32'h42, 3'd1}) begin
            bad++;
            $display("FAIL lat_cycle1: got we=%b addr=%0d din=%h cnt=%0d want we=1 addr=9 din=42 cnt=1",
                     bus.rfWe, bus.rfAddr, bus.rfDin, bus.fifoCount);
        end
        step();
        settle();
        total++;
        if ({bus.rfWe, bus.fifoCount} !== {1'b0, 3'd0}) begin
            bad++;
            $display("FAIL lat_cycle2: got we=%b cnt=%0d want we=0 cnt=0", bus.rfWe, bus.fifoCount);
        end
`endif
        step();
    endtask

    task automatic test_reset_midstream();
        drive_wb(1'b1, 5'd8, 32'h88);
        drive_mdu(1'b1, 5'd13, 32'hD0);
        step();
        drive_mdu(1'b1, 5'd14, 32'hE0);
        step();
        drive_mdu(1'b0, 5'd0, 32'h0);
        bus.queryAddr = 5'd13;
        settle();
        total++;
        if ({bus.fifoCount, bus.queryPending} !== {3'd2, 1'b1}) begin
            bad++;
            $display("FAIL mid_setup: got cnt=%0d pend=%b want cnt=2 pend=1", bus.fifoCount, bus.queryPending);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({bus.fifoCount, bus.rfWe, bus.mduReady, bus.queryPending} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset: got cnt=%0d we=%b rdy=%b pend=%b want cnt=0 we=0 rdy=0 pend=0",
                     bus.fifoCount, bus.rfWe, bus.mduReady, bus.queryPending);
        end
        step();
        step();
        rst = 1'b0;
        drive_wb(1'b0, 5'd0, 32'h0);
        settle();
        total++;
        if ({bus.mduReady, bus.rfWe, bus.fifoCount, bus.queryPending} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL mid_release: got rdy=%b we=%b cnt=%0d pend=%b want rdy=1 we=0 cnt=0 pend=0",
                     bus.mduReady, bus.rfWe, bus.fifoCount, bus.queryPending);
        end
        bus.queryAddr = 5'd0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_mdu(1'b0, 5'd0, 32'h0);
        bus.queryAddr = 5'd0;
        #1;
        test_reset();
        step();
        test_pipeline();
        step();
        test_contention();
        step();
        test_full();
        step();
        test_simultaneous();
        step();
        test_latency();
        step();
        test_reset_midstream();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
